// File: rtl/memory_access_stage.sv
// Y86-64 memory stage: classifies the M-register instruction and runs a single
// outstanding request/ack data-memory access, producing m_valM and m_stat.
module memory_access_stage #(
    parameter int MEM_BYTES      = 65536,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        M_stall_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic [3:0]  M_dstE_i,
    input  logic [3:0]  M_dstM_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [63:0] dmem_addr_o,
    output logic [63:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [63:0] dmem_rdata_i,
    input  logic        dmem_err_i,
    output logic        m_busy_o,
    output logic [2:0]  m_stat_o,
    output logic [63:0] m_valM_o,
    output logic [3:0]  m_icode_o,
    output logic [63:0] m_valE_o,
    output logic [3:0]  m_dstE_o,
    output logic [3:0]  m_dstM_o
);
    localparam logic [3:0]  IRMMOVQ = 4'h4;
    localparam logic [3:0]  IMRMOVQ = 4'h5;
    localparam logic [3:0]  ICALL   = 4'h8;
    localparam logic [3:0]  IRET    = 4'h9;
    localparam logic [3:0]  IPUSHQ  = 4'hA;
    localparam logic [3:0]  IPOPQ   = 4'hB;
    localparam logic [2:0]  SAOK    = 3'd1;
    localparam logic [2:0]  SADR    = 3'd2;
    localparam logic [63:0] ADDR_MAX   = 64'(MEM_BYTES - 8);
    localparam logic [7:0]  TIMEOUT_TC = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] valM_q, valM_d;
    logic [2:0]  stat_q, stat_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        is_rd, is_wr, in_class, stat_ok, addr_ok, need;
    logic [63:0] addr;

    always_comb begin
        is_rd    = (M_icode_i == IMRMOVQ) || (M_icode_i == IPOPQ) || (M_icode_i == IRET);
        is_wr    = (M_icode_i == IRMMOVQ) || (M_icode_i == IPUSHQ) || (M_icode_i == ICALL);
        in_class = is_rd || is_wr;
        // Pops and returns read through the stack pointer carried in valA.
        addr     = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
        stat_ok  = (M_stat_i == SAOK);
        addr_ok  = (addr <= ADDR_MAX);
        need     = in_class && stat_ok && addr_ok;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        valM_d   = valM_q;
        stat_d   = stat_q;
        cnt_d    = cnt_q;
        m_busy_o = 1'b0;
        m_stat_o = M_stat_i;
        m_valM_o = 64'd0;
        case (state_q)
            S_IDLE: begin
                if (need) begin
                    m_busy_o = 1'b1;
                    state_d  = S_WAIT;
                    req_d    = 1'b1;
                    we_d     = is_wr;
                    addr_d   = addr;
                    wdata_d  = M_valA_i;
                    cnt_d    = 8'd0;
                end else if (in_class && stat_ok) begin
                    m_stat_o = SADR;
                end
            end
            S_WAIT: begin
                m_busy_o = 1'b1;
                if (dmem_ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_DONE;
                    if (dmem_err_i) begin
                        stat_d = SADR;
                        valM_d = 64'd0;
                    end else begin
                        stat_d = SAOK;
                        valM_d = we_q ? 64'd0 : dmem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_TC) begin
                        req_d   = 1'b0;
                        stat_d  = SADR;
                        valM_d  = 64'd0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Holding here while stalled keeps the same instruction from issuing twice.
                m_stat_o = stat_q;
                m_valM_o = valM_q;
                if (!M_stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            valM_q  <= 64'd0;
            stat_q  <= 3'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valM_q  <= valM_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

    assign m_icode_o = M_icode_i;
    assign m_valE_o  = M_valE_i;
    assign m_dstE_o  = M_dstE_i;
    assign m_dstM_o  = M_dstM_i;
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Memory (M) stage logic, fed directly by the execute-to-memory pipeline register.
- Decodes the M-register icode and drives a single-outstanding request/acknowledge data-memory bus.
- Produces m_valM and m_stat for the memory-to-writeback register and the forwarding logic.
- Asserts m_busy_o to pipeline control so the M register is stalled while an access is in flight.

Parameters:
MEM_BYTES, 65536, size of the data address space in bytes; all accesses are 8 bytes
TIMEOUT_CYCLES, 255, WAIT cycles without ack before the access is aborted (1..255)

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  reset, asynchronous, active-high
M_stall_i  in  1  pipeline control is holding the M register this cycle
M_stat_i  in  3  stat from the M register
M_icode_i  in  4  icode from the M register
M_valE_i  in  64  ALU result / address
M_valA_i  in  64  store data, or stack address for IPOPQ/IRET
M_dstE_i  in  4  passthrough
M_dstM_i  in  4  passthrough
dmem_req_o  out  1  bus request, registered
dmem_we_o  out  1  1 = write, 0 = read; valid while req is high
dmem_addr_o  out  64  byte address; valid while req is high
dmem_wdata_o  out  64  write data; valid while req is high
dmem_ack_i  in  1  one-cycle completion pulse
dmem_rdata_i  in  64  read data, valid with ack
dmem_err_i  in  1  bus error, valid with ack
m_busy_o  out  1  stall request to pipeline control
m_stat_o  out  3  resulting stat
m_valM_o  out  64  loaded value
m_icode_o  out  4  passthrough of M_icode_i
m_valE_o  out  64  passthrough of M_valE_i
m_dstE_o  out  4  passthrough of M_dstE_i
m_dstM_o  out  4  passthrough of M_dstM_i

Behaviour:
- Access classes:
  - Read: IMRMOVQ, IPOPQ, IRET.
  - Write: IRMMOVQ, IPUSHQ, ICALL.
  - All other icodes (including INOP bubbles) are no access.
- Address: M_valA_i for IPOPQ/IRET; M_valE_i otherwise. Write data is always M_valA_i.
- Access is needed iff the icode is in an access class, M_stat_i == SAOK, and addr <= MEM_BYTES-8 (unsigned 64-bit compare; no wrap).
- Access class, SAOK, addr > MEM_BYTES-8: no bus activity, m_busy_o = 0, m_stat_o = SADR in the same cycle, m_valM_o = 0.
- FSM states IDLE, WAIT, DONE. Reset (async): state IDLE; dmem_req_o, dmem_we_o = 0; dmem_addr_o, dmem_wdata_o = 0; internal valM and stat registers = 0; timeout counter = 0.
- IDLE:
  - No access needed: m_busy_o = 0, m_stat_o = M_stat_i (or SADR per the range rule), m_valM_o = 0.
  - Access needed: m_busy_o = 1 combinationally. Next edge: req = 1 with we/addr/wdata registered, state -> WAIT, counter cleared.
- WAIT: m_busy_o = 1; req, we, addr, wdata held stable.
  - ack & ~err: req = 0; rdata captured if read (valM = 0 for writes); stat = SAOK; -> DONE.
  - ack & err: req = 0; stat = SADR; valM = 0; -> DONE.
  - No ack: counter increments. When counter reaches TIMEOUT_CYCLES: req = 0, stat = SADR, -> DONE. A late ack after abort is ignored.
- DONE: m_busy_o = 0; m_valM_o and m_stat_o come from the captured registers.
  - -> IDLE when ~M_stall_i.
  - Stays in DONE while M_stall_i, so the held instruction is never re-issued.
- Minimum load-to-use: 2 stall cycles (IDLE, one WAIT with immediate ack), result in the 3rd cycle.
- Passthrough ports are combinational in every state.
- rst_i mid-WAIT drops req immediately. The pending transaction is abandoned; the bus must tolerate this.

Test Plan:
- ALU op (icode IOPQ, SAOK): m_busy_o never asserts, m_stat_o = SAOK, m_valM_o = 0, dmem_req_o stays 0.
- IMRMOVQ, valE = 0x100, ack with rdata = 0xDEADBEEF in the first WAIT cycle: busy high for 2 cycles; req/addr = 0x100 with we = 0 for 1 cycle; DONE shows m_valM_o = 0xDEADBEEF, m_stat_o = SAOK.
- IPUSHQ, valE = 0x1F8, valA = 0x55, ack after 3 wait cycles: we = 1, addr = 0x1F8, wdata = 0x55 stable for 3 cycles; busy for 4 cycles; m_stat_o = SAOK.
- IPOPQ, valA = MEM_BYTES-7: no request, m_busy_o = 0, m_stat_o = SADR same cycle. IRET, valA = MEM_BYTES-8: request issued.
- IMRMOVQ, ack never arrives: req drops after 255 WAIT cycles, m_stat_o = SADR. Repeat with ack & err on cycle 2: SADR, m_valM_o = 0.
- Load enters DONE with M_stall_i = 1 for 2 cycles: no second request, valM held. Separately, rst_i asserted during WAIT: req = 0 asynchronously, state IDLE.
